iter_alu: RTL and testbench
===========================

# iter_alu

Parametrised multi-cycle integer execute unit for the MIPS pipeline's EX stage. Generalises the per-bit ALU slice to a WIDTH-bit datapath and adds iterative unsigned multiply and divide with a start/busy/done handshake. Single-cycle ops return in one cycle; MULTU/DIVU take WIDTH iterations and write a HI/LO result pair. The hazard unit stalls the pipe while `busy` is high.

## Interface
- WIDTH, 32, operand/result width (≥4)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when busy=0
- op  in  3  000 AND, 001 OR, 010 ADD, 011 NOR, 100 MULTU, 101 DIVU, 110 SUB, 111 SLT
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt/imm)
- busy  out  1  operation in progress, start ignored
- done  out  1  one-cycle pulse: results valid
- result_lo  out  WIDTH  logic/arith result, low product, or quotient
- result_hi  out  WIDTH  0 for single-cycle ops, high product, or remainder
- overflow  out  1  signed overflow, ADD/SUB only, else 0
- div_by_zero  out  1  DIVU with b=0

## Operation
- FSM states: IDLE, CALC, DONE. Reset → IDLE.
- IDLE/DONE + start: latch a, b, op; clear overflow/div_by_zero.
  - Single-cycle op: compute combinationally, register results → DONE.
  - MULTU/DIVU: load engine, count=0 → CALC.
- CALC: one iteration per cycle; count reaching WIDTH → DONE.
- DONE: done=1 for exactly one cycle → IDLE, unless start accepted in the same cycle (back-to-back issue).
- busy = (state==CALC), or the IDLE/DONE cycle in which start is accepted for MULTU/DIVU.
- Arithmetic: ADD/SUB two's complement; SUB = a + ~b + 1. overflow = carry into MSB XOR carry out of MSB.
- SLT: signed; result_lo = {WIDTH-1 zeros, less}, where less = a[MSB]&~b[MSB] ? 1 : ~a[MSB]&b[MSB] ? 0 : diff[MSB]. Correct even when the subtract overflows. overflow=0.
- MULTU: shift-add, 2*WIDTH-bit accumulator; {result_hi,result_lo} = a*b unsigned.
- DIVU: restoring; result_lo = quotient, result_hi = remainder. b=0 runs the full WIDTH iterations and yields quotient all-ones, remainder = a, div_by_zero=1.
- Result outputs hold their values from done until the next accepted start. Intermediate engine state is never visible on the outputs.
- start while busy: ignored, no effect.

## Timing
- Start accepted at edge T:
  - single-cycle op: done high during cycle T+1
  - MULTU/DIVU: done high during cycle T+WIDTH+1
- Reset: state=IDLE; busy, done, overflow, div_by_zero, result_lo, result_hi, count, engine registers all 0. rst_n low mid-CALC aborts immediately; no done pulse follows.
- Inputs are sampled only at acceptance; a, b, op may change freely afterwards.
- No combinational path from start/a/b/op to any output.

## Structure
- Package `alu_pkg`: op code localparams (OP_AND … OP_SLT), FSM state enum, count width $clog2(WIDTH)+1.
- Sub-module `alu_core`: combinational WIDTH-bit AND/OR/NOR/ADD/SUB/SLT with overflow and less. The top instantiates it once.
- Top holds the FSM, counter, and shared accumulator/remainder shift registers for MULTU/DIVU.

## Test plan (WIDTH=32)
- ADD a=0x7FFFFFFF, b=1 → result_lo 0x80000000, overflow 1, done at T+1. SUB a=0x80000000, b=1 → 0x7FFFFFFF, overflow 1.
- SLT a=0x80000000, b=1 → result_lo 1. SLT a=1, b=0x80000000 → 0. SLT a=0x7FFFFFFF, b=0xFFFFFFFF → 0 (overflow case).
- MULTU a=b=0xFFFFFFFF → hi 0xFFFFFFFE, lo 0x00000001, done exactly at T+33, busy high T..T+32.
- DIVU 100/7 → lo 14, hi 2, div_by_zero 0. DIVU 0x1234/0 → lo 0xFFFFFFFF, hi 0x1234, div_by_zero 1.
- start with op=ADD pulsed during MULTU CALC → ignored, MULTU result unaffected. New start in the DONE cycle → accepted, done one cycle later.
- rst_n low at cycle 10 of MULTU → all outputs 0 immediately, no done pulse. After release, AND 0xF0F0/0xFF00 → 0xF000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative execute unit: opcodes, FSM states and
// small helpers used by the top and the combinational core.
package alu_pkg;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_NOR   = 3'b011;
  localparam logic [2:0] OP_MULTU = 3'b100;
  localparam logic [2:0] OP_DIVU  = 3'b101;
  localparam logic [2:0] OP_SUB   = 3'b110;
  localparam logic [2:0] OP_SLT   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Iteration counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic logic is_iterative(input logic [2:0] op);
    return (op == OP_MULTU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational WIDTH-bit logic/arithmetic slice: AND, OR, NOR, ADD, SUB, SLT
// with two's-complement overflow and a signed less-than flag.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             less
);

  logic             sub_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   full_sum_s;
  logic [WIDTH-1:0] low_sum_s;
  logic             ovf_raw_s;

  assign sub_s      = (op == OP_SUB) || (op == OP_SLT);
  assign b_eff_s    = sub_s ? ~b : b;
  assign full_sum_s = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, sub_s};
  // Sum of the lower bits only; its top bit is the carry into the MSB.
  assign low_sum_s  = {1'b0, a[WIDTH-2:0]} + {1'b0, b_eff_s[WIDTH-2:0]}
                    + {{(WIDTH-1){1'b0}}, sub_s};
  assign ovf_raw_s  = low_sum_s[WIDTH-1] ^ full_sum_s[WIDTH];

  // Signed compare decided by the operand signs when they differ, so an overflowing subtract cannot flip it.
  always_comb begin
    if (a[WIDTH-1] & ~b[WIDTH-1]) begin
      less = 1'b1;
    end else if (~a[WIDTH-1] & b[WIDTH-1]) begin
      less = 1'b0;
    end else begin
      less = full_sum_s[WIDTH-1];
    end
  end

  // Result and overflow selection per opcode.
  always_comb begin
    result   = {WIDTH{1'b0}};
    overflow = 1'b0;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_NOR: result = ~(a | b);
      OP_ADD, OP_SUB: begin
        result   = full_sum_s[WIDTH-1:0];
        overflow = ovf_raw_s;
      end
      OP_SLT: result = {{(WIDTH-1){1'b0}}, less};
      default: result = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle execute unit: single-cycle ops via alu_core, MULTU/DIVU via a
// shared 2*WIDTH shift register iterated once per cycle.
module iter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic               ovf_q, ovf_d, dbz_q, dbz_d, busy_q, busy_d, done_q, done_d;

  logic [WIDTH-1:0]   core_result_s;
  logic               core_ovf_s, core_less_s;
  logic [WIDTH:0]     mul_sum_s, div_sh_s, div_trial_s;
  logic [2*WIDTH-1:0] mul_next_s, div_next_s;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a        (a),
    .b        (b),
    .op       (op),
    .result   (core_result_s),
    .overflow (core_ovf_s),
    .less     (core_less_s)
  );

  // MULTU: acc = {partial product, remaining multiplier}; add multiplicand on LSB, shift right.
  assign mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};

  // DIVU: acc = {remainder, dividend/quotient}; shift left, keep the trial subtract if non-negative.
  assign div_sh_s    = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_trial_s = div_sh_s - {1'b0, opnd_q};
  assign div_next_s  = div_trial_s[WIDTH]
                     ? {div_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                     : {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // Next-state logic for the FSM, engine and held results.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    count_d  = count_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          op_d  = op;
          ovf_d = 1'b0;
          dbz_d = 1'b0;
          if (is_iterative(op)) begin
            acc_d   = (op == OP_MULTU) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
            opnd_d  = (op == OP_MULTU) ? a : b;
            count_d = {CNT_W{1'b0}};
            state_d = S_CALC;
          end else begin
            res_lo_d = (op == OP_SLT) ? {{(WIDTH-1){1'b0}}, core_less_s} : core_result_s;
            res_hi_d = {WIDTH{1'b0}};
            ovf_d    = core_ovf_s;
            state_d  = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        acc_d   = (op_q == OP_MULTU) ? mul_next_s : div_next_s;
        count_d = count_q + CNT_ONE;
        if (count_d == CNT_LAST) begin
          res_hi_d = acc_d[2*WIDTH-1:WIDTH];
          res_lo_d = acc_d[WIDTH-1:0];
          dbz_d    = (op_q == OP_DIVU) && (opnd_q == {WIDTH{1'b0}});
          state_d  = S_DONE;
        end else begin
          state_d = S_CALC;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_CALC);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= 3'b000;
      opnd_q   <= {WIDTH{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      count_q  <= {CNT_W{1'b0}};
      res_lo_q <= {WIDTH{1'b0}};
      res_hi_q <= {WIDTH{1'b0}};
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_alu.sv
// Randomized self-checking bench for iter_alu against a transaction-level
// model (plain arithmetic, busy countdown), plus literal directed cases.
module tb_iter_alu;

  localparam int W = 32;
  localparam logic [2:0] T_AND = 3'b000, T_OR = 3'b001, T_ADD = 3'b010, T_NOR = 3'b011;
  localparam logic [2:0] T_MUL = 3'b100, T_DIV = 3'b101, T_SUB = 3'b110, T_SLT = 3'b111;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, overflow, div_by_zero;
  logic [W-1:0] result_lo, result_hi;

  int checks = 0;
  int errors = 0;

  bit           m_busy, m_done, m_ovf, m_dbz, p_ovf, p_dbz;
  int           m_left;
  logic [W-1:0] m_lo, m_hi, p_lo, p_hi;

  iter_alu #(.WIDTH(W)) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .op (op), .a (a), .b (b),
    .busy (busy), .done (done), .result_lo (result_lo), .result_hi (result_hi),
    .overflow (overflow), .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_calc(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] lo, output logic [W-1:0] hi,
                                   output bit ovf, output bit dbz);
    logic [2*W-1:0] p;
    logic [W-1:0]   s;
    lo = '0; hi = '0; ovf = 1'b0; dbz = 1'b0;
    case (o)
      T_AND: lo = x & y;
      T_OR:  lo = x | y;
      T_NOR: lo = ~(x | y);
      T_ADD: begin s = x + y; lo = s; ovf = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]); end
      T_SUB: begin s = x - y; lo = s; ovf = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]); end
      T_SLT: lo = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      T_MUL: begin p = {{W{1'b0}}, x} * {{W{1'b0}}, y}; hi = p[2*W-1:W]; lo = p[W-1:0]; end
      T_DIV: begin
        if (y == '0) begin lo = '1; hi = x; dbz = 1'b1; end
        else begin lo = x / y; hi = x % y; end
      end
      default: lo = '0;
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_ovf = 0; m_dbz = 0; m_left = 0; m_lo = '0; m_hi = '0;
  endtask

  // Advance the model across the coming clock edge using the inputs now driven.
  task automatic model_apply();
    if (start && !m_busy) begin
      ref_calc(op, a, b, p_lo, p_hi, p_ovf, p_dbz);
      m_ovf = 0; m_dbz = 0;
      if (op == T_MUL || op == T_DIV) begin
        m_busy = 1; m_left = W; m_done = 0;
      end else begin
        m_busy = 0; m_done = 1; m_lo = p_lo; m_hi = p_hi; m_ovf = p_ovf;
      end
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1; m_lo = p_lo; m_hi = p_hi; m_dbz = p_dbz;
      end else begin
        m_done = 0;
      end
    end else begin
      m_done = 0;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
    if (m_done) begin
      chk("result_lo", 64'(result_lo), 64'(m_lo));
      chk("result_hi", 64'(result_hi), 64'(m_hi));
    end
  endtask

  task automatic drive(input bit st, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = st; op = o; a = x; b = y;
    model_apply();
  endtask

  task automatic step(input bit st, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    sample();
    drive(st, o, x, y);
  endtask

  // Issue one op, wait (bounded) for done and pin the outputs to literal values.
  task automatic run_lit(input string name, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] e_lo, input logic [W-1:0] e_hi, input bit e_ovf, input bit e_dbz,
                         input int e_lat, input int poke, input bit b2b);
    bit got = 0;
    int n = 0;
    step(1'b1, o, x, y);
    while (!got && n < W + 8) begin
      sample();
      n++;
      if (done === 1'b1) begin
        got = 1;
        chk({name, " latency"}, 64'(n), 64'(e_lat));
        chk({name, " lo"}, 64'(result_lo), 64'(e_lo));
        chk({name, " hi"}, 64'(result_hi), 64'(e_hi));
        chk({name, " ovf"}, 64'(overflow), 64'(e_ovf));
        chk({name, " dbz"}, 64'(div_by_zero), 64'(e_dbz));
      end
      if (got && b2b) drive(1'b1, T_ADD, 32'd5, 32'd6);
      else if (n == poke) drive(1'b1, T_ADD, $urandom, $urandom);
      else drive(1'b0, T_AND, '0, '0);
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s timeout: no done within %0d cycles", name, W + 8);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    model_reset();
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset lo", 64'(result_lo), 64'd0);
    chk("reset hi", 64'(result_hi), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, T_AND, '0, '0);

    run_lit("add_ovf", T_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 32'd0, 1, 0, 1, -1, 0);
    run_lit("sub_ovf", T_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 32'd0, 1, 0, 1, -1, 0);
    run_lit("slt_neg", T_SLT, 32'h8000_0000, 32'd1, 32'd1, 32'd0, 0, 0, 1, -1, 0);
    run_lit("slt_pos", T_SLT, 32'd1, 32'h8000_0000, 32'd0, 32'd0, 0, 0, 1, -1, 0);
    run_lit("slt_wrap", T_SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, 0, 1, -1, 0);
    run_lit("multu_max", T_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 0, 0, 33, 5, 1);
    sample();
    chk("b2b done", 64'(done), 64'd1);
    chk("b2b lo", 64'(result_lo), 64'd11);
    drive(1'b0, T_AND, '0, '0);
    run_lit("divu", T_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 33, -1, 0);
    run_lit("divu_zero", T_DIV, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 0, 1, 33, -1, 0);

    // Abort a multiply with reset; no done may follow.
    step(1'b1, T_MUL, 32'hFFFF_FFFF, 32'd3);
    for (int i = 0; i < 10; i++) step(1'b0, T_AND, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort lo", 64'(result_lo), 64'd0);
    chk("abort hi", 64'(result_hi), 64'd0);
    chk("abort flags", 64'({overflow, div_by_zero}), 64'd0);
    model_reset();
    repeat (2) sample();
    rst_n = 1'b1;
    drive(1'b0, T_AND, '0, '0);
    for (int i = 0; i < W + 4; i++) step(1'b0, T_AND, '0, '0);
    run_lit("and", T_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 32'd0, 0, 0, 1, -1, 0);

    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), pick(), pick());
    for (int i = 0; i < W + 4; i++) step(1'b0, T_AND, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
